// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: state encoding and
// the default timing / lap-memory sizing.
package stopwatch_pkg;

    // Sequencer states, encoded as they appear on the state output
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STOP   = 2'b10,
        ST_RECALL = 2'b11
    } state_t;

    // 100 ms count tick at a 50 MHz system clock
    localparam int DEF_TICK_DIV = 5000000;

    // Number of lap slots in the external lap memory
    localparam int DEF_LAPS = 4;

endpackage

// File: rtl/tick_gen.sv
// Prescaler that turns the system clock into a one-cycle count tick.
// The count freezes while disabled so a stopped watch resumes mid-period.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic key0,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] presc;

    // Advance the prescaler while enabled, pulse tick on wrap, hold otherwise
    always_ff @(posedge clk or negedge key0) begin
        if (!key0) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (presc == LAST) begin
                presc <= '0;
                tick  <= 1'b1;
            end else begin
                presc <= presc + ONE;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch / lap-timer control sequencer. Turns edge-detected button
// pulses into run state, count ticks, counter clears, lap writes and lap
// recall addressing for the external datapath.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int LAPS     = DEF_LAPS,
    parameter int LAP_W    = 2
) (
    input  logic             clk,
    input  logic             key0,
    input  logic             ss_push,
    input  logic             lap_push,
    input  logic             recall_push,
    input  logic             clr_push,
    output logic             run,
    output logic             tick,
    output logic             time_clr,
    output logic             lap_we,
    output logic [LAP_W-1:0] lap_waddr,
    output logic             lap_full,
    output logic             show_lap,
    output logic [LAP_W-1:0] lap_raddr,
    output logic [1:0]       state
);

    localparam logic [LAP_W:0]   LAP_MAX   = (LAP_W + 1)'(LAPS);
    localparam logic [LAP_W:0]   CNT_ONE   = (LAP_W + 1)'(1);
    localparam logic [LAP_W-1:0] RADDR_ONE = LAP_W'(1);

    state_t         st;
    state_t         ret_st;
    logic [LAP_W:0] lap_cnt;
    logic           gen_en;
    logic           gen_clr;
    logic           lap_ok;
    logic           last_lap;

    // The prescaler only advances on RUN cycles that are not being stopped,
    // so the edge that takes the stop pulse leaves its value untouched.
    assign gen_en   = (st == ST_RUN) && !ss_push;
    assign gen_clr  = clr_push && ((st == ST_STOP) || (st == ST_RECALL));
    assign lap_ok   = lap_push && (lap_cnt < LAP_MAX);
    assign last_lap = ({1'b0, lap_raddr} == (lap_cnt - CNT_ONE));
    assign state    = st;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .key0(key0),
        .en  (gen_en),
        .clr (gen_clr),
        .tick(tick)
    );

    // Sequencer state, lap bookkeeping and all registered control strobes
    always_ff @(posedge clk or negedge key0) begin
        if (!key0) begin
            st        <= ST_IDLE;
            ret_st    <= ST_IDLE;
            lap_cnt   <= '0;
            run       <= 1'b0;
            time_clr  <= 1'b0;
            lap_we    <= 1'b0;
            lap_waddr <= '0;
            lap_full  <= 1'b0;
            show_lap  <= 1'b0;
            lap_raddr <= '0;
        end else begin
            time_clr <= 1'b0;
            lap_we   <= 1'b0;
            if (gen_clr) begin
                st        <= ST_IDLE;
                run       <= 1'b0;
                time_clr  <= 1'b1;
                lap_cnt   <= '0;
                lap_full  <= 1'b0;
                show_lap  <= 1'b0;
                lap_raddr <= '0;
            end else begin
                unique case (st)
                    ST_IDLE: begin
                        if (ss_push) begin
                            st  <= ST_RUN;
                            run <= 1'b1;
                        end else if (recall_push && (lap_cnt != '0)) begin
                            st        <= ST_RECALL;
                            ret_st    <= ST_IDLE;
                            show_lap  <= 1'b1;
                            lap_raddr <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (lap_ok) begin
                            lap_we    <= 1'b1;
                            lap_waddr <= lap_cnt[LAP_W-1:0];
                            lap_cnt   <= lap_cnt + CNT_ONE;
                            lap_full  <= ((lap_cnt + CNT_ONE) == LAP_MAX);
                        end
                        if (ss_push) begin
                            st  <= ST_STOP;
                            run <= 1'b0;
                        end
                    end
                    ST_STOP: begin
                        if (ss_push) begin
                            st  <= ST_RUN;
                            run <= 1'b1;
                        end else if (recall_push && (lap_cnt != '0)) begin
                            st        <= ST_RECALL;
                            ret_st    <= ST_STOP;
                            show_lap  <= 1'b1;
                            lap_raddr <= '0;
                        end
                    end
                    ST_RECALL: begin
                        if (recall_push) begin
                            if (last_lap) begin
                                st        <= ret_st;
                                show_lap  <= 1'b0;
                                lap_raddr <= '0;
                            end else begin
                                lap_raddr <= lap_raddr + RADDR_ONE;
                            end
                        end
                    end
                    default: begin
                        st  <= ST_IDLE;
                        run <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
